// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner, frame-level press/release tracking and a shifting seven-segment entry buffer.
// Define KEYPAD_DEBOUNCE_EN to require DEBOUNCE_SCANS identical frames for press and release.
module keypad_hex_entry #(
  parameter int COL_DWELL      = 50000,
  parameter int SAMPLE_OFFSET  = 8,
  parameter int DIGITS         = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  Row,
  output logic [3:0]                  Col,
  input  logic                        en,
  input  logic                        clr,
  output logic                        key_valid,
  output logic [3:0]                  DecodeOut,
  output logic                        key_held,
  output logic [DIGITS*8-1:0]         seg,
  output logic [$clog2(DIGITS+1)-1:0] digit_count
);
  localparam int CW = $clog2(COL_DWELL);
  localparam int NW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] LAST = CW'(COL_DWELL - 1);
  localparam logic [CW-1:0] SOFF = CW'(SAMPLE_OFFSET);
  // Key code for each frame bit, indexed by {column, Row bit}.
  localparam logic [63:0]  KEYMAP = 64'hABCD_369E_258F_1470;
  localparam logic [127:0] SEGTAB = 128'h8E86_A1C6_8388_9080_F882_9299_B0A4_F9C0;

  if (COL_DWELL < 2 || SAMPLE_OFFSET >= COL_DWELL || DIGITS < 1 || DEBOUNCE_SCANS < 1) begin : g_bad_params
    $error("keypad_hex_entry: illegal parameter combination");
  end

  typedef enum logic [1:0] {DRIVE, SAMPLE, DWELL} scan_t;
  scan_t               state;
  logic [CW-1:0]       dwell;
  logic [1:0]          col, col_nxt;
  logic [15:0]         samp, frame;
  logic [4:0]          nlow;
  logic [3:0]          code;
  logic                col_end, frame_end, sample_now, single, none, accept, release_k;
  logic [DIGITS*8-1:0] shifted;

  assign col_end    = (dwell == LAST);
  assign frame_end  = col_end && (col == 2'd3);
  assign sample_now = (state != DWELL) && (dwell == SOFF);
  assign col_nxt    = col_end ? col + 2'd1 : col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DRIVE;
      dwell <= '0;
      col   <= 2'd0;
      Col   <= 4'b1111;
      samp  <= '1;
    end else begin
      dwell <= col_end ? '0 : dwell + CW'(1);
      col   <= col_nxt;
      Col   <= ~(4'b1000 >> col_nxt);
      if (col_end)           state <= DRIVE;
      else if (dwell < SOFF) state <= SAMPLE;
      else                   state <= DWELL;
      if (sample_now) samp[{col, 2'b00} +: 4] <= Row;
    end
  end

  // Column 3 may be sampled on the frame's last cycle, so bypass the live row in.
  always_comb begin
    frame = samp;
    if (sample_now) frame[{col, 2'b00} +: 4] = Row;
    nlow = '0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (!frame[i]) begin
        nlow = nlow + 5'd1;
        code = KEYMAP[i*4 +: 4];
      end
    end
  end

  assign single = (nlow == 5'd1);
  assign none   = (nlow == 5'd0);

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int SW = $clog2(DEBOUNCE_SCANS+1);
  localparam logic [SW-1:0] NEED = SW'(DEBOUNCE_SCANS);
  logic [SW-1:0] stab, stab_nxt, stab_inc;
  logic [3:0]    cand;

  assign stab_inc = (stab == NEED) ? stab : stab + SW'(1);

  always_comb begin
    accept    = 1'b0;
    release_k = 1'b0;
    stab_nxt  = stab;
    if (frame_end) begin
      if (!key_held) begin
        stab_nxt = '0;
        if (single) stab_nxt = (code == cand && stab != '0) ? stab_inc : SW'(1);
        if (single && stab_nxt >= NEED) begin
          accept   = 1'b1;
          stab_nxt = '0;
        end
      end else begin
        stab_nxt = none ? stab_inc : '0;
        if (none && stab_nxt >= NEED) begin
          release_k = 1'b1;
          stab_nxt  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab <= '0;
      cand <= '0;
    end else begin
      stab <= stab_nxt;
      if (frame_end && single && !key_held) cand <= code;
    end
  end
`else
  assign accept    = frame_end && !key_held && single;
  assign release_k = frame_end && key_held && none;
`endif

  always_comb begin
    shifted      = seg << 8;
    shifted[7:0] = SEGTAB[code*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid   <= 1'b0;
      DecodeOut   <= 4'd0;
      key_held    <= 1'b0;
      seg         <= '1;
      digit_count <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        DecodeOut <= code;
        key_held  <= 1'b1;
      end else if (release_k) begin
        key_held  <= 1'b0;
      end
      if (clr) begin
        seg         <= '1;
        digit_count <= '0;
      end else if (accept && en) begin
        seg <= shifted;
        if (digit_count != NW'(DIGITS)) digit_count <= digit_count + NW'(1);
      end
    end
  end
endmodule

// File: doc/keypad_hex_entry.md
# keypad_hex_entry

Parametrised 4x4 hex keypad scanner with frame-based debounce and a DIGITS-deep shifting seven-segment entry buffer for the DE10-Lite keypad/display path. Each key press yields one single-cycle `key_valid` strobe and a 4-bit code on `DecodeOut`. While entry is enabled, the new digit shifts into digit 0 and older digits move toward digit DIGITS-1. It sits between the keypad header pins and the HEX display drivers.

## Interface
- `COL_DWELL`, 50000: cycles each column is driven; 1 ms at 50 MHz; must be ≥ 2.
- `SAMPLE_OFFSET`, 8: cycles after a column goes low before `Row` is sampled; must be < `COL_DWELL`.
- `DIGITS`, 4: display digits held; must be ≥ 1.
- `DEBOUNCE_SCANS`, 3: consecutive identical frames required; must be ≥ 1; used only with the debounce macro.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Row` in 4: keypad rows, active-low, externally pulled up.
- `Col` out 4: keypad columns; exactly one bit is low while scanning.
- `en` in 1: when 1, accepted keys shift into the display buffer.
- `clr` in 1: synchronous clear of the display buffer.
- `key_valid` out 1: one-cycle strobe per accepted press.
- `DecodeOut` out 4: code of the last accepted key; held until the next accepted key.
- `key_held` out 1: 1 from acceptance until the release is accepted.
- `seg` out DIGITS*8: digit i occupies `seg[8i+7:8i]`; segments active-low; bit 7 is DP, always 1.
- `digit_count` out $clog2(DIGITS+1): digits entered, saturating at DIGITS.

## Operation
- Key map, column c with `Col` bit (3-c) low, row r with `Row` bit (3-r) low:
  - c0: 1, 4, 7, 0.
  - c1: 2, 5, 8, F.
  - c2: 3, 6, 9, E.
  - c3: A, B, C, D.
- Scan FSM: states DRIVE → SAMPLE → DWELL, repeated for columns 0 to 3, then back to column 0.
  - The dwell counter is $clog2(COL_DWELL) bits wide and wraps at COL_DWELL-1.
  - The column index wraps from 3 to 0.
- Frame classification, from the four samples:
  - NONE: all samples are 4'b1111.
  - SINGLE: exactly one low bit across the whole frame; carries that key's code.
  - MULTI: more than one low bit, within one column or across columns.
- Press/release tracking, with state IDLE or HELD:
  - IDLE, and SINGLE frames of the same code meet the threshold: accept the key; `key_valid`=1 for one cycle, `DecodeOut` is loaded, state → HELD.
  - HELD, and NONE frames meet the threshold: state → IDLE; no strobe on release.
  - SINGLE with a code different from the held key, while HELD: treated as not-NONE; no new key until a release is accepted.
  - MULTI: resets the stability counter and leaves the state unchanged.
- Entry buffer, on `key_valid` with `en`=1:
  - digit i ← digit i-1 for i ≥ 1; digit 0 ← segment pattern of the new code.
  - `digit_count` increments, saturating at DIGITS.
- Segment patterns, 0 to F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E. A blank digit is FF.
- `en`=0: `key_valid`, `DecodeOut` and `key_held` still update; `seg` and `digit_count` are unchanged.
- `clr`=1: all digits become FF and `digit_count` becomes 0.
  - If `clr` coincides with `key_valid`, `clr` wins; the key still strobes and loads `DecodeOut`.
- Reset values: `Col`=4'b1111, `key_valid`=0, `DecodeOut`=0, `key_held`=0, every `seg` digit 8'hFF, `digit_count`=0. FSM is at DRIVE of column 0, with all counters at 0.

## Timing
- Frame length is 4*COL_DWELL cycles, counted from the first cycle after reset deasserts.
- Column c is driven low during cycles c*COL_DWELL to (c+1)*COL_DWELL-1 of each frame.
- `Row` is registered at cycle c*COL_DWELL+SAMPLE_OFFSET.
- A frame is classified on its last cycle. `key_valid`, `DecodeOut`, `seg` and `digit_count` update together on the next cycle, which is cycle 0 of the next frame.
- Latency from a press that is stable before a frame starts to `key_valid`: N frames + 1 cycle, where N = DEBOUNCE_SCANS (1 without the macro).
- `rst_n` asserted mid-frame: all outputs return to their reset values immediately; the partial frame is discarded.

## Configuration
- `KEYPAD_DEBOUNCE_EN` defined:
  - Acceptance needs DEBOUNCE_SCANS consecutive SINGLE frames of the same code.
  - Release needs DEBOUNCE_SCANS consecutive NONE frames.
  - The stability counter is $clog2(DEBOUNCE_SCANS+1) bits wide and saturates.
- Not defined: a single SINGLE frame accepts and a single NONE frame releases. The counter is absent and DEBOUNCE_SCANS is ignored.

## Test plan
- Reset, with `rst_n` low for 5 cycles mid-frame → `Col`=1111, `seg`=32'hFFFFFFFF, `digit_count`=0, `key_valid`=0; the scan restarts at column 0.
- Hold key 5 (`Row`=1011 while `Col`=1011) for 3 frames, then keep holding for 10 more, with the macro on and DEBOUNCE_SCANS=3 → exactly one `key_valid`; `DecodeOut`=5, `seg[7:0]`=8'h92, `digit_count`=1, `key_held`=1.
- Enter 1, 2, 3, 4, 5 with full press/release cycles → `seg`=32'hA4B09992 and `digit_count`=4.
- Press and release key 7 on alternating frames for 6 frames (macro on) → no `key_valid`. The same stimulus with the macro off → 3 strobes, each with `DecodeOut`=7.
- Press keys 1 and 2 together for 5 frames → no `key_valid`; `key_held` stays 0.
- Pulse `clr` on the cycle `key_valid` fires for key A → `seg` all FF, `digit_count`=0, `DecodeOut`=A. Then press 0 with `en`=0 → strobe seen, `seg` unchanged.
